lanectrl_pause_sequencer: RTL and testbench

Round-robin scheduler that shares one lane controller's HS_IO_CLK_PAUSE input among several requesters, e.g. the DQS delay-line updater, write-leveling training and the periodic recalibration engine. Each requester needs the high-speed IO clock paused around a delay or code update. The block brackets every granted update with programmable guard intervals and enforces a minimum gap between consecutive pauses. Its HS_IO_CLK_PAUSE output drives the lane-control pause synchronizer directly.

---
 rtl/lanectrl_pause_sequencer_if.sv | 22 ++
 rtl/lanectrl_pause_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_lanectrl_pause_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lanectrl_pause_sequencer_if.sv
// Handshake bundle between the pause requesters and lanectrl_pause_sequencer.
// The master side belongs to the requesters and the slave side to the sequencer.
interface lanectrl_pause_sequencer_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] REQ;
  logic [NUM_REQ-1:0] UPD_DONE;
  logic [NUM_REQ-1:0] GNT;
  logic               HS_IO_CLK_PAUSE;
  logic               BUSY;
  logic               ERR;

  modport master (
    output REQ, UPD_DONE,
    input  GNT, HS_IO_CLK_PAUSE, BUSY, ERR
  );

  modport slave (
    input  REQ, UPD_DONE,
    output GNT, HS_IO_CLK_PAUSE, BUSY, ERR
  );
endinterface

// File: rtl/lanectrl_pause_sequencer.sv
// Round-robin owner of the lane HS_IO_CLK_PAUSE input: guarded pause, grant, guard, gap.
// Optional GRANT watchdog with sticky ERR when PAUSE_TIMEOUT_EN is defined.
module lanectrl_pause_sequencer #(
  parameter int NUM_REQ        = 4,
  parameter int PRE_CYCLES     = 2,
  parameter int POST_CYCLES    = 2,
  parameter int GAP_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                       CLK,
  input logic                       RESET,
  lanectrl_pause_sequencer_if.slave bus
);

  localparam int         IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] PRE_LOAD  = 4'(PRE_CYCLES);
  localparam logic [3:0] POST_LOAD = 4'(POST_CYCLES);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES);

  generate
    if (NUM_REQ < 1 || NUM_REQ > 8 ||
        PRE_CYCLES < 1 || PRE_CYCLES > 15 ||
        POST_CYCLES < 1 || POST_CYCLES > 15 ||
        GAP_CYCLES < 1 || GAP_CYCLES > 15 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
      $error("lanectrl_pause_sequencer: parameter out of legal range");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_GRANT,
    S_POST,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               pause_q, pause_d;
  logic               busy_q, busy_d;
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;

`ifdef PAUSE_TIMEOUT_EN
  localparam logic [7:0] WD_LOAD = 8'(TIMEOUT_CYCLES);
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
`endif

  // Requester index 'offs' places after 'base', wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // ptr_q holds the highest-priority index, i.e. one past the last granted requester.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && bus.REQ[rr_idx(ptr_q, i)]) begin
        win_vld = 1'b1;
        win_idx = rr_idx(ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef PAUSE_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          idx_d   = win_idx;
          cnt_d   = PRE_LOAD;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (cnt_q == 4'd1) begin
          if (bus.REQ[idx_q]) begin
            state_d = S_GRANT;
            ptr_d   = rr_idx(idx_q, 1);
`ifdef PAUSE_TIMEOUT_EN
            wd_d    = WD_LOAD;
`endif
          end else begin
            // Requester withdrew: still close the pause with the post guard, pointer untouched.
            state_d = S_POST;
            cnt_d   = POST_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_GRANT: begin
        if (bus.UPD_DONE[idx_q]) begin
          state_d = S_POST;
          cnt_d   = POST_LOAD;
        end
`ifdef PAUSE_TIMEOUT_EN
        else if (wd_q == 8'd1) begin
          state_d = S_POST;
          cnt_d   = POST_LOAD;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q - 8'd1;
        end
`endif
      end
      S_POST: begin
        if (cnt_q == 4'd1) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs derive from the next state and are registered, so they only move on transitions.
    pause_d = (state_d == S_PRE) || (state_d == S_GRANT) || (state_d == S_POST);
    busy_d  = (state_d != S_IDLE);
    gnt_d   = '0;
    if (state_d == S_GRANT) gnt_d[idx_d] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      pause_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      pause_q <= pause_d;
      busy_q  <= busy_d;
    end
  end

`ifdef PAUSE_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign bus.ERR = err_q;
`else
  assign bus.ERR = 1'b0;
`endif

  assign bus.GNT             = gnt_q;
  assign bus.HS_IO_CLK_PAUSE = pause_q;
  assign bus.BUSY            = busy_q;

endmodule

// File: tb/tb_lanectrl_pause_sequencer.sv
// Self-checking bench for lanectrl_pause_sequencer: scenario tasks plus randomized
// sequences checked cycle by cycle against a timeline model of each pause.
module tb_lanectrl_pause_sequencer;

  localparam int N    = 4;
  localparam int PRE  = 2;
  localparam int POST = 2;
  localparam int GAP  = 3;
`ifdef PAUSE_TIMEOUT_EN
  localparam int TO   = 8;
`else
  localparam int TO   = 255;
`endif

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  lanectrl_pause_sequencer_if #(.NUM_REQ(N)) bus ();

  lanectrl_pause_sequencer #(
    .NUM_REQ        (N),
    .PRE_CYCLES     (PRE),
    .POST_CYCLES    (POST),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: next-priority index and sticky error.
  int model_ptr = 0;
  bit model_err = 1'b0;

  // Observations from the most recent sequence.
  int pause_width;
  int gnt_width;
  int gap_low;
  int busy_tail;
  int obs_idx;
  int grant_log[$];

  function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (mask[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge CLK);
    RESET        = 1'b1;
    bus.REQ      = '0;
    bus.UPD_DONE = '0;
    @(negedge CLK);
    RESET     = 1'b0;
    model_ptr = 0;
    model_err = 1'b0;
  endtask

  // One full pause sequence starting at an IDLE sample; g = grant length in cycles.
  // Timeline after the sampling edge: PRE pause cycles, g grant cycles, POST guard,
  // GAP busy cycles, then one IDLE cycle before the next request can be sampled.
  task automatic run_seq(input logic [N-1:0] mask, input int g, input bit cancel,
                         input bit no_done, input logic [N-1:0] stray, input string tag);
    int               win;
    int               gl;
    int               t_end;
    logic [N-1:0]     oh;
    logic [N-1:0]     e_gnt;
    logic             e_pause;
    logic             e_busy;
    logic             e_err;
    win   = rr_pick(mask, model_ptr);
    oh    = '0;
    oh[win] = 1'b1;
    gl    = cancel ? 0 : g;
    t_end = PRE + gl + POST + GAP + 1;
    pause_width = 0;
    gnt_width   = 0;
    gap_low     = 0;
    busy_tail   = 0;
    obs_idx     = -1;
    bus.REQ     = mask;
    for (int t = 1; t <= t_end; t++) begin
      @(negedge CLK);
      e_pause = (t <= PRE + gl + POST);
      e_busy  = (t <= PRE + gl + POST + GAP);
      e_gnt   = (t > PRE && t <= PRE + gl) ? oh : '0;
      e_err   = model_err || (no_done && t > PRE + gl);
      n_checks++;
      if ({bus.GNT, bus.HS_IO_CLK_PAUSE, bus.BUSY, bus.ERR} !== {e_gnt, e_pause, e_busy, e_err}) begin
        n_errors++;
        $display("FAIL %s t=%0d gnt/pause/busy/err got %b/%b/%b/%b want %b/%b/%b/%b",
                 tag, t, bus.GNT, bus.HS_IO_CLK_PAUSE, bus.BUSY, bus.ERR,
                 e_gnt, e_pause, e_busy, e_err);
      end
      if (bus.HS_IO_CLK_PAUSE === 1'b1) pause_width++;
      if (bus.GNT !== '0) gnt_width++;
      if (t > PRE + gl + POST && bus.HS_IO_CLK_PAUSE === 1'b0) gap_low++;
      if (bus.HS_IO_CLK_PAUSE === 1'b0 && bus.BUSY === 1'b1) busy_tail++;
      if (t == PRE + 1) begin
        for (int i = 0; i < N; i++) if (bus.GNT[i] === 1'b1) obs_idx = i;
      end
      // Inputs for the next edge.
      if (cancel) bus.REQ = '0;
      bus.UPD_DONE = '0;
      if (!cancel && t > PRE && t < PRE + gl) bus.UPD_DONE = stray & ~oh;
      if (!cancel && !no_done && t == PRE + gl) bus.UPD_DONE = oh;
    end
    if (!cancel) begin
      n_checks++;
      if (obs_idx !== win) begin
        n_errors++;
        $display("FAIL %s grant index got %0d want %0d", tag, obs_idx, win);
      end
      grant_log.push_back(obs_idx);
      model_ptr = (win + 1) % N;
    end
    if (no_done) model_err = 1'b1;
  endtask

  task automatic test_reset();
    RESET        = 1'b1;
    bus.REQ      = '0;
    bus.UPD_DONE = '0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({bus.GNT, bus.HS_IO_CLK_PAUSE, bus.BUSY, bus.ERR} !== '0) begin
      n_errors++;
      $display("FAIL reset_values got gnt/pause/busy/err %b/%b/%b/%b want all 0",
               bus.GNT, bus.HS_IO_CLK_PAUSE, bus.BUSY, bus.ERR);
    end
    RESET = 1'b0;
  endtask

  task automatic test_defaults();
    run_seq(4'b0001, 3, 1'b0, 1'b0, '0, "defaults");
    bus.REQ = '0;
    n_checks++;
    if (pause_width !== 7 || gnt_width !== 3 || busy_tail !== 3) begin
      n_errors++;
      $display("FAIL defaults_widths pause/gnt/busy_tail got %0d/%0d/%0d want 7/3/3",
               pause_width, gnt_width, busy_tail);
    end
  endtask

  task automatic test_fairness();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    grant_log.delete();
    for (int k = 0; k < 5; k++) begin
      run_seq(4'b1111, 1, 1'b0, 1'b0, '0, "fairness");
      n_checks++;
      if (gap_low !== GAP + 1) begin
        n_errors++;
        $display("FAIL fairness_gap seq=%0d low cycles got %0d want %0d", k, gap_low, GAP + 1);
      end
    end
    bus.REQ = '0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (grant_log[k] !== exp_order[k]) begin
        n_errors++;
        $display("FAIL fairness_order slot=%0d got %0d want %0d", k, grant_log[k], exp_order[k]);
      end
    end
  endtask

  task automatic test_withdrawal();
    run_seq(4'b0100, 0, 1'b1, 1'b0, '0, "withdraw");
    n_checks++;
    if (pause_width !== PRE + POST || gnt_width !== 0) begin
      n_errors++;
      $display("FAIL withdraw_width pause/gnt got %0d/%0d want %0d/0", pause_width, gnt_width, PRE + POST);
    end
    // Pointer still at 1 -> index 2 beats index 0.
    run_seq(4'b0101, 1, 1'b0, 1'b0, '0, "withdraw_ptr");
    bus.REQ = '0;
    n_checks++;
    if (obs_idx !== 2) begin
      n_errors++;
      $display("FAIL withdraw_ptr_kept got %0d want 2", obs_idx);
    end
  endtask

  task automatic test_stray_done();
    run_seq(4'b1000, 4, 1'b0, 1'b0, 4'b0010, "stray_done");
    bus.REQ = '0;
    n_checks++;
    if (gnt_width !== 4) begin
      n_errors++;
      $display("FAIL stray_done_gnt_width got %0d want 4", gnt_width);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    for (int k = 0; k < 40; k++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      run_seq(mask, int'($urandom_range(1, 5)), ($urandom_range(0, 4) == 0),
              1'b0, N'($urandom), "random");
      if ($urandom_range(0, 2) == 0) bus.REQ = '0;
    end
    bus.REQ = '0;
  endtask

`ifdef PAUSE_TIMEOUT_EN
  task automatic test_timeout();
    run_seq(4'b0001, TO, 1'b0, 1'b1, '0, "timeout");
    bus.REQ = '0;
    n_checks++;
    if (gnt_width !== TO || pause_width !== PRE + TO + POST) begin
      n_errors++;
      $display("FAIL timeout_widths gnt/pause got %0d/%0d want %0d/%0d",
               gnt_width, pause_width, TO, PRE + TO + POST);
    end
    run_seq(4'b0010, 2, 1'b0, 1'b0, '0, "timeout_err_sticky");
    bus.REQ = '0;
  endtask
`endif

  task automatic test_reset_mid_grant();
    logic [N-1:0] e_gnt;
    e_gnt = '0;
    e_gnt[rr_pick(4'b0100, model_ptr)] = 1'b1;
    bus.REQ = 4'b0100;
    repeat (PRE + 1) @(negedge CLK);
    n_checks++;
    if (bus.GNT !== e_gnt) begin
      n_errors++;
      $display("FAIL rst_mid_grant_pre got %b want %b", bus.GNT, e_gnt);
    end
    #2 RESET = 1'b1;
    #1;
    n_checks++;
    if ({bus.GNT, bus.HS_IO_CLK_PAUSE, bus.BUSY, bus.ERR} !== '0) begin
      n_errors++;
      $display("FAIL rst_mid_grant_async gnt/pause/busy/err got %b/%b/%b/%b want all 0",
               bus.GNT, bus.HS_IO_CLK_PAUSE, bus.BUSY, bus.ERR);
    end
    @(negedge CLK);
    bus.REQ   = '0;
    RESET     = 1'b0;
    model_ptr = 0;
    model_err = 1'b0;
    run_seq(4'b1010, 2, 1'b0, 1'b0, '0, "rst_then_req");
    bus.REQ = '0;
    n_checks++;
    if (obs_idx !== 1) begin
      n_errors++;
      $display("FAIL rst_then_req_first got %0d want 1", obs_idx);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_defaults();
    test_fairness();
    test_withdrawal();
    test_stray_done();
    test_random();
`ifdef PAUSE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_grant();
    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
